// File: rtl/axis_arb_rr.sv
// rtl/axis_arb_rr.sv - packet-level round-robin arbiter sharing one AXI-stream path
module axis_arb_rr #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  output logic                            grant_active
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]  grant_q, grant_d;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]  pick;
  logic [NUM_PORTS-1:0] req_rot;
  logic                 last_beat;
  int                   off;
  int                   sum;

  // Round-robin pick: rotate requests so bit 0 is the port just after the last
  // winner, take the lowest set bit, then map the offset back to a port index.
  always_comb begin
    req_rot = NUM_PORTS'({2{s_axis_tvalid}} >> (int'(ptr_q) + 1));
    off     = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off = i;
      end
    end
    sum = int'(ptr_q) + 1 + off;
    if (sum >= NUM_PORTS) begin
      sum = sum - NUM_PORTS;
    end
    pick = ID_WIDTH'(sum);
  end

  // State register: grant and pointer only move at arbitration / packet end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= ID_WIDTH'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: grant on any request in IDLE, release on the tlast handshake.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    last_beat = (state_q == ST_BUSY) & s_axis_tvalid[grant_q] &
                m_axis_tready & s_axis_tlast[grant_q];
    case (state_q)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          grant_d = pick;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (last_beat) begin
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: zero-latency mux of the granted port; handshake only while BUSY.
  always_comb begin
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    m_axis_tdata  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    m_axis_tlast  = s_axis_tlast[grant_q];
    if (state_q == ST_BUSY) begin
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  assign m_axis_tid   = grant_q;
  assign grant_active = (state_q == ST_BUSY);

endmodule

// File: tb/tb_axis_arb_rr.sv
// tb/tb_axis_arb_rr.sv - randomized self-checking bench for axis_arb_rr
module tb_axis_arb_rr;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [IW-1:0] m_tid;
  logic          grant_active;

  always #5 clk = ~clk;

  axis_arb_rr #(.NUM_PORTS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .grant_active(grant_active)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // beats are {tlast, tdata}; drv_q feeds the sources, exp_q is the scoreboard
  logic [DW:0] drv_q [N][$];
  logic [DW:0] exp_q [N][$];
  int  vprob [N];
  int  rprob;
  bit  rdy_toggle;
  // reference model of the arbitration rules
  bit  busy_m;
  int  gnt_m;
  int  last_m;
  // packet order as seen on the DUT output (tid of each first beat)
  int  dut_log [$];
  int  exp_log [$];
  bit  dut_first;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int p = 0; p < N; p++) s += exp_q[p].size();
    return s;
  endfunction

  task automatic add_beat(input int p, input logic [DW-1:0] d, input logic l);
    drv_q[p].push_back({l, d});
    exp_q[p].push_back({l, d});
  endtask

  task automatic add_pkt(input int p, input int len);
    for (int i = 0; i < len; i++) add_beat(p, $urandom, (i == len - 1));
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      if (drv_q[p].size() > 0) begin
        s_tvalid[p] = ($urandom_range(99) < vprob[p]);
        s_tdata[p*DW +: DW] = drv_q[p][0][DW-1:0];
        s_tlast[p] = drv_q[p][0][DW];
      end else begin
        s_tvalid[p] = 1'b0;
        s_tdata[p*DW +: DW] = $urandom;
        s_tlast[p] = 1'($urandom_range(1));
      end
    end
    if (rdy_toggle) m_tready = ~m_tready;
    else m_tready = ($urandom_range(99) < rprob);
  endtask

  // one clock: check outputs mid-cycle, advance model and sources at the edge
  task automatic step();
    int g;
    bit exp_valid, hs, last_hs;
    int exp_rdy;
    logic [N-1:0] s_hs;
    @(negedge clk);
    g = gnt_m;
    exp_valid = busy_m && s_tvalid[g];
    exp_rdy = (busy_m && m_tready) ? (1 << g) : 0;
    check("m_tvalid", m_tvalid, exp_valid);
    check("s_tready", s_tready, exp_rdy);
    check("grant_active", grant_active, busy_m);
    if (busy_m) check("m_tid", m_tid, g);
    hs = exp_valid && m_tready;
    last_hs = 1'b0;
    s_hs = s_tvalid & s_tready;
    if (hs) begin
      if (exp_q[g].size() == 0) begin
        check("sb_nonempty", exp_q[g].size(), 1);
      end else begin
        check("m_tdata", m_tdata, exp_q[g][0][DW-1:0]);
        check("m_tlast", m_tlast, exp_q[g][0][DW]);
        last_hs = exp_q[g][0][DW];
        void'(exp_q[g].pop_front());
      end
    end
    if (m_tvalid && m_tready) begin
      if (dut_first) dut_log.push_back(int'(m_tid));
      dut_first = m_tlast;
    end
    @(posedge clk);
    for (int p = 0; p < N; p++)
      if (s_hs[p] && drv_q[p].size() > 0) void'(drv_q[p].pop_front());
    if (busy_m) begin
      if (hs && last_hs) begin
        busy_m = 1'b0;
        last_m = g;
      end
    end else if (|s_tvalid) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last_m + k) % N;
        if (s_tvalid[c]) begin
          gnt_m = c;
          break;
        end
      end
      busy_m = 1'b1;
    end
    #1;
    drive();
  endtask

  task automatic run(input int max_cycles);
    int cyc = 0;
    drive();
    while ((pending() > 0 || busy_m) && cyc < max_cycles) begin
      step();
      cyc++;
    end
    check("drain_timeout", pending(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_tvalid = '0;
    m_tready = 1'b0;
    for (int p = 0; p < N; p++) begin
      drv_q[p].delete();
      exp_q[p].delete();
      vprob[p] = 100;
    end
    rprob = 100;
    rdy_toggle = 1'b0;
    busy_m = 1'b0;
    gnt_m = 0;
    last_m = N - 1;
    dut_log.delete();
    dut_first = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tid", m_tid, 0);
    check("rst_grant_active", grant_active, 0);
    rst_n = 1'b1;
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, dut_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++)
      check({tag, "_tid"}, dut_log[i], exp_log[i]);
  endtask

  initial begin
    s_tvalid = '0;
    s_tdata = '0;
    s_tlast = '0;
    m_tready = 1'b0;
    do_reset();

    // single port, three beats
    add_beat(0, 32'h11, 1'b0);
    add_beat(0, 32'h22, 1'b0);
    add_beat(0, 32'h33, 1'b1);
    run(50);
    exp_log = '{0};
    check_log("t1_order");

    // three ports waiting after reset are served 0,1,2
    do_reset();
    add_pkt(0, 2); add_pkt(1, 2); add_pkt(2, 2);
    run(100);
    exp_log = '{0, 1, 2};
    check_log("t2_order");

    // alternating downstream ready
    do_reset();
    rdy_toggle = 1'b1;
    add_pkt(1, 4);
    run(100);
    rdy_toggle = 1'b0;
    exp_log = '{1};
    check_log("t3_order");

    // granted port stalls mid-packet while another port waits
    do_reset();
    add_pkt(1, 6);
    drive();
    step();
    step();
    vprob[1] = 30;
    add_pkt(2, 2);
    run(300);
    exp_log = '{1, 2};
    check_log("t4_order");

    // two continuous requesters alternate
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add_pkt(0, 1);
      add_pkt(3, 1);
    end
    run(100);
    exp_log = '{0, 3, 0, 3, 0, 3, 0, 3};
    check_log("t5_order");

    // reset in the middle of a packet, then restart from the reset pointer
    do_reset();
    add_pkt(0, 4);
    drive();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("t6_m_tvalid", m_tvalid, 0);
    check("t6_s_tready", s_tready, 0);
    check("t6_m_tid", m_tid, 0);
    check("t6_grant_active", grant_active, 0);
    do_reset();
    add_pkt(2, 2);
    add_pkt(0, 2);
    run(100);
    exp_log = '{0, 2};
    check_log("t6_order");

    // randomized traffic, pointer carried across rounds
    do_reset();
    for (int r = 0; r < 10; r++) begin
      for (int p = 0; p < N; p++) begin
        vprob[p] = $urandom_range(40, 100);
        repeat ($urandom_range(0, 2)) add_pkt(p, $urandom_range(1, 5));
      end
      rprob = $urandom_range(40, 100);
      run(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
